// File: rtl/exe_mem_pkg.sv
// Shared types and default sizes for the EXE->MEM pipeline stage.
// Used by exe_mem_slot and exe_mem_stage_buf.
package exe_mem_pkg;

    // Default sizes of the vector datapath
    localparam int unsigned EXE_MEM_LANES  = 4;
    localparam int unsigned EXE_MEM_DATA_W = 32;
    localparam int unsigned EXE_MEM_RD_W   = 4;

    // Number of single-bit control flags carried alongside rd
    localparam int unsigned EXE_MEM_FLAG_W = 4;

    // Write-back / memory control word at the default rd width.
    // Field order is also the bit order used when packing the word.
    typedef struct packed {
        logic                    regWrite;
        logic                    memWrite;
        logic                    updateCnt;
        logic                    select;
        logic [EXE_MEM_RD_W-1:0] rd;
    } stage_ctrl_t;

    // Occupancy of the two-slot buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // The stage can take a beat in every state except TWO
    function automatic logic can_accept(input state_t s);
        return (s != TWO);
    endfunction

endpackage

// File: rtl/exe_mem_slot.sv
// One payload entry of the EXE->MEM stage (instantiated as MAIN and SKID).
// Control word loads whole on i_load. Each lane loads its data and compare
// bit only when its i_lane_en bit is set; a masked lane keeps its old data
// and has its compare bit forced to 0. Asynchronous active-low clear.
module exe_mem_slot #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [LANES-1:0]        i_lane_en,
    input  logic [CTRL_W-1:0]       i_ctrl,
    input  logic [LANES-1:0]        i_cmp,
    input  logic [LANES*DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0]       o_ctrl,
    output logic [LANES-1:0]        o_cmp,
    output logic [LANES*DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0]       r_ctrl;
    logic [LANES-1:0]        r_cmp;
    logic [LANES*DATA_W-1:0] r_data;

    // Control word: replaced whole on every load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Per-lane capture: enabled lanes take new data, masked lanes hold data and clear compare
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cmp[g]                    <= 1'b0;
                r_data[g*DATA_W +: DATA_W]  <= '0;
            end else if (i_load) begin
                if (i_lane_en[g]) begin
                    r_cmp[g]                   <= i_cmp[g];
                    r_data[g*DATA_W +: DATA_W] <= i_data[g*DATA_W +: DATA_W];
                end else begin
                    r_cmp[g]                   <= 1'b0;
                end
            end
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_cmp  = r_cmp;
    assign o_data = r_data;

endmodule

// File: rtl/exe_mem_stage_buf.sv
// EXE->MEM pipeline stage with a valid/ready handshake and a two-entry
// (MAIN + SKID) buffer so that memory-stage back-pressure reaches the
// execute stage only through a register. Synchronous flush squashes all
// held beats. Optional build macro: EXE_MEM_LANE_MASK_EN adds the lane_en
// port for per-lane capture masking.
//
// Handshake: a beat moves when valid and ready are both high at the rising
// clock edge; a producer keeps its beat stable while valid is high and ready
// is low. in_ready is a register; out_valid and the payload come from MAIN.
module exe_mem_stage_buf
    import exe_mem_pkg::*;
#(
    parameter int unsigned LANES  = EXE_MEM_LANES,
    parameter int unsigned DATA_W = EXE_MEM_DATA_W,
    parameter int unsigned RD_W   = EXE_MEM_RD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    regWrite_in,
    input  logic                    memWrite_in,
    input  logic                    updateCnt_in,
    input  logic                    select_in,
    input  logic [RD_W-1:0]         rd_in,
    input  logic [LANES-1:0]        resCompare_in,
    input  logic [LANES*DATA_W-1:0] aluRes_in,
`ifdef EXE_MEM_LANE_MASK_EN
    input  logic [LANES-1:0]        lane_en,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    regWrite_out,
    output logic                    memWrite_out,
    output logic                    updateCnt_out,
    output logic                    select_out,
    output logic [RD_W-1:0]         rd_out,
    output logic [LANES-1:0]        resCompare_out,
    output logic [LANES*DATA_W-1:0] aluRes_out,
    output state_t                  o_dbg_state
);

    // Control word at this instance's rd width (same layout as stage_ctrl_t)
    typedef struct packed {
        logic            regWrite;
        logic            memWrite;
        logic            updateCnt;
        logic            select;
        logic [RD_W-1:0] rd;
    } ctrl_word_t;

    localparam int unsigned CTRL_W = $bits(ctrl_word_t);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;
    logic   w_in_ready_nxt;

    logic   w_accept;
    logic   w_consume;
    logic   w_out_valid;
    logic   w_main_load;
    logic   w_skid_load;
    logic   w_main_from_skid;

    logic [LANES-1:0]        w_in_lane_en;
    ctrl_word_t              w_in_ctrl;

    logic [LANES-1:0]        w_main_lane_en;
    ctrl_word_t              w_main_ctrl_d;
    logic [LANES-1:0]        w_main_cmp_d;
    logic [LANES*DATA_W-1:0] w_main_data_d;

    ctrl_word_t              w_main_ctrl_q;
    logic [LANES-1:0]        w_main_cmp_q;
    logic [LANES*DATA_W-1:0] w_main_data_q;

    ctrl_word_t              w_skid_ctrl_q;
    logic [LANES-1:0]        w_skid_cmp_q;
    logic [LANES*DATA_W-1:0] w_skid_data_q;

`ifdef EXE_MEM_LANE_MASK_EN
    assign w_in_lane_en = lane_en;
`else
    assign w_in_lane_en = '1;
`endif

    assign w_in_ctrl.regWrite  = regWrite_in;
    assign w_in_ctrl.memWrite  = memWrite_in;
    assign w_in_ctrl.updateCnt = updateCnt_in;
    assign w_in_ctrl.select    = select_in;
    assign w_in_ctrl.rd        = rd_in;

    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_consume   = w_out_valid & out_ready;

    // State register and registered in_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    // Next state and slot load strobes; flush overrides every transition
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && !w_consume) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = TWO;
                    end else if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a consume can happen
                    if (w_consume) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
        w_in_ready_nxt = can_accept(w_state_nxt);
    end

    // MAIN input: the new beat, or the SKID entry copied verbatim (already merged)
    always_comb begin
        w_main_lane_en = w_in_lane_en;
        w_main_ctrl_d  = w_in_ctrl;
        w_main_cmp_d   = resCompare_in;
        w_main_data_d  = aluRes_in;
        if (w_main_from_skid) begin
            w_main_lane_en = '1;
            w_main_ctrl_d  = w_skid_ctrl_q;
            w_main_cmp_d   = w_skid_cmp_q;
            w_main_data_d  = w_skid_data_q;
        end
    end

    exe_mem_slot #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_load    (w_main_load),
        .i_lane_en (w_main_lane_en),
        .i_ctrl    (w_main_ctrl_d),
        .i_cmp     (w_main_cmp_d),
        .i_data    (w_main_data_d),
        .o_ctrl    (w_main_ctrl_q),
        .o_cmp     (w_main_cmp_q),
        .o_data    (w_main_data_q)
    );

    exe_mem_slot #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_load    (w_skid_load),
        .i_lane_en (w_in_lane_en),
        .i_ctrl    (w_in_ctrl),
        .i_cmp     (resCompare_in),
        .i_data    (aluRes_in),
        .o_ctrl    (w_skid_ctrl_q),
        .o_cmp     (w_skid_cmp_q),
        .o_data    (w_skid_data_q)
    );

    // Write strobes are qualified by out_valid so an empty or squashed stage never writes
    assign in_ready       = r_in_ready;
    assign out_valid      = w_out_valid;
    assign regWrite_out   = w_out_valid & w_main_ctrl_q.regWrite;
    assign memWrite_out   = w_out_valid & w_main_ctrl_q.memWrite;
    assign updateCnt_out  = w_out_valid & w_main_ctrl_q.updateCnt;
    assign select_out     = w_main_ctrl_q.select;
    assign rd_out         = w_main_ctrl_q.rd;
    assign resCompare_out = w_main_cmp_q;
    assign aluRes_out     = w_main_data_q;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/exe_mem_stage_buf.md
# exe_mem_stage_buf

Parametrised EXE→MEM pipeline stage of the vector encryption CPU, carrying LANES lane results plus the write-back/memory control word from the execute stage to the memory stage. Unlike a plain stage register, it uses a valid/ready handshake with a two-entry skid buffer, so memory-stage back-pressure never combinationally reaches the execute stage. It also supports a synchronous flush for branch/compare squash. It sits between the vector ALU array and the data-memory/write-back logic.

## Interface
- LANES, 4, number of vector lanes
- DATA_W, 32, width of each lane result
- RD_W, 4, destination register index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  execute stage presents a beat
- in_ready  out  1  stage can accept a beat (registered)
- regWrite_in, memWrite_in, updateCnt_in, select_in  in  1 each  control word
- rd_in  in  RD_W  destination register
- resCompare_in  in  LANES  per-lane compare flags
- aluRes_in  in  LANES×DATA_W  packed lane results, lane 0 in LSBs
- lane_en  in  LANES  per-lane capture enable (present only with EXE_MEM_LANE_MASK_EN)
- out_valid  out  1  memory stage has a beat
- out_ready  in  1  memory stage consumes the beat
- regWrite_out, memWrite_out, updateCnt_out  out  1 each  control strobes, gated by out_valid
- select_out  out  1  raw select bit of the head entry
- rd_out, resCompare_out, aluRes_out  out  as inputs  head-entry payload

## Operation
- Two slots: MAIN, which drives the outputs, and SKID. State is EMPTY, ONE (MAIN valid) or TWO (both valid).
- Accept when in_valid & in_ready. Consume when out_valid & out_ready.
- EMPTY: an accepted beat goes to MAIN, and the state becomes ONE.
- ONE:
  - Accept without consume: the beat goes to SKID, and the state becomes TWO.
  - Accept with consume: the beat replaces MAIN, and the state stays ONE.
  - Consume only: the state becomes EMPTY.
- TWO: in_ready=0. On consume, SKID moves to MAIN and the state becomes ONE.
- in_ready is registered and equals "next state ≠ TWO".
- flush has priority over everything else:
  - Next state is EMPTY and in_ready becomes 1.
  - A beat accepted in the flush cycle is discarded.
  - Payload registers are not cleared.
- Control strobes regWrite_out, memWrite_out and updateCnt_out are ANDed with out_valid, so a squashed or empty stage never writes. All other outputs show MAIN contents regardless of valid.
- Width rule: aluRes_out is exactly LANES×DATA_W. There is no truncation or extension anywhere.

## Timing
- Latency from accept to out_valid is 1 cycle. Throughput is 1 beat/cycle while out_ready=1.
- out_ready → in_ready takes one register stage: a deassertion is seen at in_ready one cycle later, and SKID absorbs the extra beat.
- While reset is low:
  - in_ready=1 and out_valid=0.
  - All strobes, select_out, rd_out, resCompare_out and aluRes_out are 0.
  - The state is EMPTY.
- Reset asserted mid-operation drops all held beats immediately (asynchronous).
- Ordering is strictly FIFO. There is no reordering or duplication.

## Configuration
- EXE_MEM_LANE_MASK_EN defined:
  - The lane_en port exists. On accept, only lanes with lane_en[i]=1 load aluRes and resCompare.
  - A masked lane keeps that slot's previous data, and its resCompare bit is forced to 0.
  - When SKID moves to MAIN, the SKID contents (already merged) are copied.
- Undefined: no lane_en port, and all lanes are always captured.

## Structure
- Package exe_mem_pkg:
  - stage_ctrl_t packed struct {regWrite, memWrite, updateCnt, select, rd}
  - state enum {EMPTY, ONE, TWO}
  - default LANES/DATA_W/RD_W localparams
- Sub-module exe_mem_slot: one payload entry with load enable, optional per-lane mask, and async active-low clear. It is instantiated twice (MAIN, SKID).

## Test plan
- Reset low then high, with in_valid=1, rd_in=4'h5, aluRes lane0=32'hDEADBEEF, out_ready=1 → in_ready=1; next cycle out_valid=1, rd_out=5, lane0=DEADBEEF, and regWrite_out follows regWrite_in.
- Stream 8 beats (rd=0..7) with out_ready toggling 1,0,0,1 → exactly 8 beats out in order 0..7, with no loss or duplication. in_ready drops only when the state is TWO.
- Fill TWO (beats A, B), then assert flush in the same cycle as in_valid beat C → next cycle out_valid=0, in_ready=1, memWrite_out=0; C is never output.
- Hold out_ready=0 for 5 cycles with in_valid=1 → exactly 2 beats accepted, in_ready=0 from cycle 2 on. Then release → beats emerge 1 per cycle.
- With EXE_MEM_LANE_MASK_EN: beat 1 all lanes 32'h1111_1111, beat 2 lane_en=4'b0101 data 32'h2222_2222 → lanes 0,2=2222_2222, lanes 1,3 hold 1111_1111, resCompare_out[1]=resCompare_out[3]=0.
- Drop reset while in TWO → outputs zero asynchronously (before the next clk edge), and in_ready=1.
